// File: rtl/mcseq_pkg.sv
// Shared definitions for the multicycle sequencer and the downstream control-signal generator.
package mcseq_pkg;

    localparam int unsigned ILEN      = 32;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned TYPE_W    = 3;

    localparam logic [STATE_W-1:0] FETCH   = 4'b0000;
    localparam logic [STATE_W-1:0] DECODE  = 4'b0001;
    localparam logic [STATE_W-1:0] EXECUTE = 4'b0010;
    localparam logic [STATE_W-1:0] WB      = 4'b1111;
    localparam logic [STATE_W-1:0] NEXT    = 4'b0100;
    localparam logic [STATE_W-1:0] TRAP    = 4'b1110;

    localparam logic [TYPE_W-1:0] TYPE_LOAD   = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_OPIMM  = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_STORE  = 3'b010;
    localparam logic [TYPE_W-1:0] TYPE_OP     = 3'b011;
    localparam logic [TYPE_W-1:0] TYPE_BRANCH = 3'b110;

    localparam logic [ILEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = FETCH,
        S_DECODE  = DECODE,
        S_EXECUTE = EXECUTE,
        S_WB      = WB,
        S_NEXT    = NEXT,
        S_TRAP    = TRAP
    } state_e;

    // Register/function fields of the instruction register as seen by the generator.
    typedef struct packed {
        logic [6:0]        funct7;
        logic [4:0]        rs2;
        logic [4:0]        rs1;
        logic [2:0]        funct3;
        logic [4:0]        rd;
        logic [TYPE_W-1:0] itype;
    } ir_fields_t;

    function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
        return (t == TYPE_LOAD) || (t == TYPE_OPIMM) || (t == TYPE_STORE)
            || (t == TYPE_OP) || (t == TYPE_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_ir_fields.sv
// Combinational split of the instruction register into named fields and the B-type immediate.
module multicycle_sequencer_ir_fields
    import mcseq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] ir_i,
    output ir_fields_t      fields_o,
    output logic [XLEN-1:0] imm_b_o
);

    localparam int unsigned IMMB_W = 13;

    logic unused_opcode_lo;

    always_comb begin
        fields_o.funct7 = ir_i[31:25];
        fields_o.rs2    = ir_i[24:20];
        fields_o.rs1    = ir_i[19:15];
        fields_o.funct3 = ir_i[14:12];
        fields_o.rd     = ir_i[11:7];
        fields_o.itype  = ir_i[6:4];
    end

    // Branch offset is sign-extended from bit 12; bit 0 is always zero.
    assign imm_b_o = {{(XLEN-IMMB_W){ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};

    assign unused_opcode_lo = ^ir_i[3:0];

endmodule

// File: rtl/multicycle_sequencer.sv
// Main state sequencer of the multicycle RV32 datapath: fetch handshake, IR, PC and retire count.
// Optional MCSEQ_ILLEGAL_TRAP_EN: illegal instruction types park the sequencer in TRAP until reset.
module multicycle_sequencer
    import mcseq_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     EXEC_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [ILEN-1:0]     imem_rdata,
    input  logic                branch_taken,
    output logic [STATE_W-1:0]  state,
    output logic [TYPE_W-1:0]   ir_type,
    output logic [2:0]          funct3,
    output logic [6:0]          funct7,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     pc,
    output logic                pc_write,
    output logic [31:0]         retired
`ifdef MCSEQ_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_instr
`endif
);

    localparam int unsigned     CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [ILEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              take_q, take_d;
    logic              pcw_q, pcw_d;
    logic [31:0]       ret_q, ret_d;
`ifdef MCSEQ_ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_d;
`endif

    ir_fields_t        fields;
    logic [XLEN-1:0]   imm_b;

    multicycle_sequencer_ir_fields #(
        .XLEN (XLEN)
    ) u_ir_fields (
        .ir_i     (ir_q),
        .fields_o (fields),
        .imm_b_o  (imm_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            req_q     <= 1'b0;
            ir_q      <= NOP_WORD;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            take_q    <= 1'b0;
            pcw_q     <= 1'b0;
            ret_q     <= '0;
`ifdef MCSEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            take_q    <= take_d;
            pcw_q     <= pcw_d;
            ret_q     <= ret_d;
`ifdef MCSEQ_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next-state and registered-output logic; req and pc_write default low every cycle.
    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        ir_d      = ir_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        take_d    = take_q;
        pcw_d     = 1'b0;
        ret_d     = ret_q;
`ifdef MCSEQ_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif

        unique case (state_q)
            S_FETCH: begin
                // An ack only counts once the request is visible on the bus.
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    req_d   = 1'b1;
                end
            end
            S_DECODE: begin
`ifdef MCSEQ_ILLEGAL_TRAP_EN
                if (!is_legal_type(fields.itype)) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d   = S_EXECUTE;
                    cnt_d     = CNT_LOAD;
                end
`else
                state_d = S_EXECUTE;
                cnt_d   = CNT_LOAD;
`endif
            end
            S_EXECUTE: begin
                if (cnt_q == '0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_WB: begin
                take_d  = branch_taken && (fields.itype == TYPE_BRANCH);
                pcw_d   = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                pc_d    = take_q ? (pc_q + imm_b) : (pc_q + XLEN'(4));
                ret_d   = ret_q + 32'd1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign state     = state_q;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_write  = pcw_q;
    assign retired   = ret_q;
    assign ir_type   = fields.itype;
    assign funct3    = fields.funct3;
    assign funct7    = fields.funct7;
    assign rs1       = fields.rs1;
    assign rs2       = fields.rs2;
    assign rd        = fields.rd;
`ifdef MCSEQ_ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`endif

endmodule
